// File: rtl/systolic_cmd_sched.sv
// Command scheduler for the systolic memory controller.
// Jobs are queued, launched one at a time with a calc_init pulse, and retired
// when the controller's current_state goes back to IDLE or the start times out.
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on queue fullness, never on
// cmd_valid, and a transferred illegal command is dropped rather than queued.
module systolic_cmd_sched #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TAG_W         = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_mode,
  input  logic [31:0]                   cmd_left,
  input  logic [31:0]                   cmd_right,
  input  logic [31:0]                   cmd_addsrc,
  input  logic [31:0]                   cmd_save,
  input  logic [10:0]                   cmd_size,
  input  logic [TAG_W-1:0]              cmd_tag,
  input  logic [3:0]                    engine_state,
  output logic                          calc_init,
  output logic [2:0]                    mem_mode,
  output logic [31:0]                   base_left,
  output logic [31:0]                   base_right,
  output logic [31:0]                   base_addsrc,
  output logic [31:0]                   base_save,
  output logic [10:0]                   matrix_size,
  output logic                          done_valid,
  output logic [TAG_W-1:0]              done_tag,
  output logic                          done_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level,
  output logic                          err_bad_cmd,
  output logic                          err_start_timeout,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_DONE
  } state_t;

  // Queue storage (no reset needed: only entries below queue_level are read)
  logic [2:0]       mode_mem   [FIFO_DEPTH];
  logic [31:0]      left_mem   [FIFO_DEPTH];
  logic [31:0]      right_mem  [FIFO_DEPTH];
  logic [31:0]      addsrc_mem [FIFO_DEPTH];
  logic [31:0]      save_mem   [FIFO_DEPTH];
  logic [10:0]      size_mem   [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem    [FIFO_DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             avail_q, avail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             calc_init_q, calc_init_d;
  logic [2:0]       mem_mode_q, mem_mode_d;
  logic [31:0]      left_q, left_d, right_q, right_d;
  logic [31:0]      addsrc_q, addsrc_d, save_q, save_d;
  logic [10:0]      size_q, size_d;
  logic             done_valid_q, done_valid_d, done_err_q, done_err_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic             busy_q, busy_d;
  logic             bad_q, bad_d, tmo_q, tmo_d;

  logic full, cmd_fire, cmd_legal, push, pop, timeout_evt;

  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign cmd_ready = !full && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_legal = ((cmd_mode == 3'd1) || (cmd_mode == 3'd2)) && (cmd_size != 11'd0) &&
                     (cmd_left[2:0] == 3'd0) && (cmd_right[2:0] == 3'd0) &&
                     (cmd_addsrc[2:0] == 3'd0) && (cmd_save[2:0] == 3'd0);
  assign push      = cmd_fire && cmd_legal;
  assign pop       = (state_q == S_DONE);

  // Queue pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + LW'(1);
    else if (!push && pop) count_d = count_q - LW'(1);
    // A freshly written entry becomes eligible for launch one cycle after its write
    avail_d  = (count_q != '0);
    bad_d    = (cmd_fire && !cmd_legal) ? 1'b1 : (err_clr ? 1'b0 : bad_q);
    tmo_d    = timeout_evt ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
  end

  // Launch/track FSM next state and registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    calc_init_d  = 1'b0;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    done_tag_d   = done_tag_q;
    mem_mode_d   = mem_mode_q;
    left_d       = left_q;
    right_d      = right_q;
    addsrc_d     = addsrc_q;
    save_d       = save_q;
    size_d       = size_q;
    timeout_evt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && avail_q) begin
          state_d     = S_LAUNCH;
          calc_init_d = 1'b1;
          mem_mode_d  = mode_mem[rd_ptr_q];
          left_d      = left_mem[rd_ptr_q];
          right_d     = right_mem[rd_ptr_q];
          addsrc_d    = addsrc_mem[rd_ptr_q];
          save_d      = save_mem[rd_ptr_q];
          size_d      = size_mem[rd_ptr_q];
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_START;
        cnt_d   = '0;
      end
      S_WAIT_START: begin
        if (engine_state != 4'd0) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d      = S_DONE;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
          done_tag_d   = tag_mem[rd_ptr_q];
          timeout_evt  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (engine_state == 4'd0) begin
          state_d      = S_DONE;
          done_valid_d = 1'b1;
          done_tag_d   = tag_mem[rd_ptr_q];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Queue write port
  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr_q]   <= cmd_mode;
      left_mem[wr_ptr_q]   <= cmd_left;
      right_mem[wr_ptr_q]  <= cmd_right;
      addsrc_mem[wr_ptr_q] <= cmd_addsrc;
      save_mem[wr_ptr_q]   <= cmd_save;
      size_mem[wr_ptr_q]   <= cmd_size;
      tag_mem[wr_ptr_q]    <= cmd_tag;
    end
  end

  // State, queue control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      avail_q      <= 1'b0;
      cnt_q        <= '0;
      calc_init_q  <= 1'b0;
      mem_mode_q   <= '0;
      left_q       <= '0;
      right_q      <= '0;
      addsrc_q     <= '0;
      save_q       <= '0;
      size_q       <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_tag_q   <= '0;
      busy_q       <= 1'b0;
      bad_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      avail_q      <= avail_d;
      cnt_q        <= cnt_d;
      calc_init_q  <= calc_init_d;
      mem_mode_q   <= mem_mode_d;
      left_q       <= left_d;
      right_q      <= right_d;
      addsrc_q     <= addsrc_d;
      save_q       <= save_d;
      size_q       <= size_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      done_tag_q   <= done_tag_d;
      busy_q       <= busy_d;
      bad_q        <= bad_d;
      tmo_q        <= tmo_d;
    end
  end

  assign calc_init         = calc_init_q;
  assign mem_mode          = mem_mode_q;
  assign base_left         = left_q;
  assign base_right        = right_q;
  assign base_addsrc       = addsrc_q;
  assign base_save         = save_q;
  assign matrix_size       = size_q;
  assign done_valid        = done_valid_q;
  assign done_tag          = done_tag_q;
  assign done_err          = done_err_q;
  assign busy              = busy_q;
  assign queue_level       = count_q;
  assign err_bad_cmd       = bad_q;
  assign err_start_timeout = tmo_q;

endmodule

// File: tb/tb_systolic_cmd_sched.sv
// Bench for systolic_cmd_sched: directed scenarios plus a randomized job mix,
// checked against a job-level model (queue of accepted jobs, expected errors).
module tb_systolic_cmd_sched;

  logic        clk, rst, cmd_valid, cmd_ready;
  logic [2:0]  cmd_mode;
  logic [31:0] cmd_left, cmd_right, cmd_addsrc, cmd_save;
  logic [10:0] cmd_size;
  logic [3:0]  cmd_tag, engine_state;
  logic        calc_init;
  logic [2:0]  mem_mode;
  logic [31:0] base_left, base_right, base_addsrc, base_save;
  logic [10:0] matrix_size;
  logic        done_valid, done_err, busy, err_bad_cmd, err_start_timeout, err_clr;
  logic [3:0]  done_tag;
  logic [2:0]  queue_level;

  systolic_cmd_sched #(.FIFO_DEPTH(4), .TAG_W(4), .START_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_addsrc(cmd_addsrc), .cmd_save(cmd_save), .cmd_size(cmd_size),
    .cmd_tag(cmd_tag), .engine_state(engine_state), .calc_init(calc_init),
    .mem_mode(mem_mode), .base_left(base_left), .base_right(base_right),
    .base_addsrc(base_addsrc), .base_save(base_save), .matrix_size(matrix_size),
    .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
    .busy(busy), .queue_level(queue_level), .err_bad_cmd(err_bad_cmd),
    .err_start_timeout(err_start_timeout), .err_clr(err_clr)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] l, r, a, s;
    logic [10:0] size;
    logic [3:0]  tag;
  } job_t;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  job_t       model_q[$];
  logic [0:0] exp_err_q[$];
  int checks = 0, errors = 0;
  int model_level = 0, max_level = 0, cyc = 0, due_cyc = 0, n_done = 0;
  int eng_mode = 0;  // 0 manual, 1 random, 2 always starts, 3 never starts
  bit mon_en = 0, pop_pending = 0, due_active = 0, exp_bad = 0, exp_to = 0, prev_ci = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input job_t j);
    return ((j.mode == 3'd1) || (j.mode == 3'd2)) && (j.size != 0) &&
           (j.l % 8 == 0) && (j.r % 8 == 0) && (j.a % 8 == 0) && (j.s % 8 == 0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [2:0] m, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] a, input logic [31:0] s,
                          input logic [10:0] sz, input logic [3:0] tg);
    job_t j;
    int w;
    j.mode = m; j.l = l; j.r = r; j.a = a; j.s = s; j.size = sz; j.tag = tg;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_left = l; cmd_right = r;
    cmd_addsrc = a; cmd_save = s; cmd_size = sz; cmd_tag = tg;
    w = 0;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready) begin
      @(posedge clk);
      if (is_legal(j)) begin
        model_q.push_back(j);
        model_level++;
      end else begin
        exp_bad = 1'b1;
      end
      #2 cmd_valid = 1'b0;
    end else begin
      chk("push_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    exp_bad = 1'b0;
    exp_to  = 1'b0;
    #2 err_clr = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (model_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    chk("drain_jobs_left", 64'(model_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- controller behaviour ----------------
  initial begin : engine_model
    bit resp;
    int d, run;
    engine_state = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (calc_init && eng_mode != 0) begin
        resp = (eng_mode == 2) || (eng_mode == 1 && $urandom_range(0, 3) != 0);
        exp_err_q.push_back(!resp);
        if (resp) begin
          d   = $urandom_range(0, 2);
          run = (eng_mode == 2) ? $urandom_range(10, 20) : $urandom_range(3, 12);
          repeat (d) @(negedge clk);
          for (int i = 0; i < run; i++) begin
            @(negedge clk);
            engine_state = 4'($urandom_range(1, 15));
          end
          @(negedge clk);
          engine_state = 4'd0;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    logic [0:0] e;
    #1;
    cyc++;
    if (mon_en) begin
      if (pop_pending) begin
        model_level--;
        pop_pending = 0;
      end
      if (due_active && cyc == due_cyc) begin
        chk("relaunch_gap", 64'(calc_init), 64'd1);
        due_active = 0;
      end
      if (calc_init) begin
        chk("calc_init_single", 64'(prev_ci), 64'd0);
        chk("calc_init_has_job", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          chk("cfg_mode",   64'(mem_mode),    64'(model_q[0].mode));
          chk("cfg_left",   64'(base_left),   64'(model_q[0].l));
          chk("cfg_right",  64'(base_right),  64'(model_q[0].r));
          chk("cfg_addsrc", 64'(base_addsrc), 64'(model_q[0].a));
          chk("cfg_save",   64'(base_save),   64'(model_q[0].s));
          chk("cfg_size",   64'(matrix_size), 64'(model_q[0].size));
        end
      end
      if (done_valid) begin
        chk("done_has_job", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          chk("done_tag", 64'(done_tag), 64'(model_q[0].tag));
          e = (exp_err_q.size() != 0) ? exp_err_q.pop_front() : 1'b0;
          chk("done_err", 64'(done_err), 64'(e));
          if (e) exp_to = 1'b1;
          if (model_q.size() > 1) begin
            due_active = 1;
            due_cyc    = cyc + 2;
          end
          void'(model_q.pop_front());
          pop_pending = 1;
          n_done++;
        end
      end
      chk("queue_level", 64'(queue_level), 64'(model_level));
      chk("err_bad_cmd", 64'(err_bad_cmd), 64'(exp_bad));
      chk("err_start_timeout", 64'(err_start_timeout), 64'(exp_to));
      if (int'(queue_level) > max_level) max_level = int'(queue_level);
      prev_ci = calc_init;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stimulus
    int k;
    job_t j;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_left = '0; cmd_right = '0;
    cmd_addsrc = '0; cmd_save = '0; cmd_size = '0; cmd_tag = '0; err_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_calc_init",  64'(calc_init),   64'd0);
    chk("rst_cmd_ready",  64'(cmd_ready),   64'd0);
    chk("rst_busy",       64'(busy),        64'd0);
    chk("rst_level",      64'(queue_level), 64'd0);
    chk("rst_done_valid", 64'(done_valid),  64'd0);
    chk("rst_mem_mode",   64'(mem_mode),    64'd0);
    chk("rst_base_left",  64'(base_left),   64'd0);
    chk("rst_err_bad",    64'(err_bad_cmd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Single job with a hand-driven controller
    eng_mode = 0;
    exp_err_q.push_back(1'b0);
    push_cmd(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 11'd64, 4'd3);
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!calc_init && k < 20);
    chk("launch_latency", 64'(k), 64'd2);
    @(negedge clk);
    @(negedge clk);
    engine_state = 4'd1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("single_no_reinit", 64'(calc_init),   64'd0);
      chk("single_mode",      64'(mem_mode),    64'd1);
      chk("single_left",      64'(base_left),   64'h1000);
      chk("single_size",      64'(matrix_size), 64'd64);
      chk("single_busy",      64'(busy),        64'd1);
    end
    engine_state = 4'd0;
    @(posedge clk);
    #1;
    chk("single_done_valid", 64'(done_valid), 64'd1);
    chk("single_done_tag",   64'(done_tag),   64'd3);
    chk("single_done_err",   64'(done_err),   64'd0);
    @(posedge clk);
    #1;
    chk("single_busy_after", 64'(busy),       64'd0);
    chk("single_done_once",  64'(done_valid), 64'd0);
    chk("single_cfg_hold",   64'(base_left),  64'h1000);

    // Back-to-back: five jobs, the last waits for cmd_ready
    eng_mode  = 2;
    max_level = 0;
    for (int t = 0; t < 5; t++)
      push_cmd(3'(1 + (t % 2)), 32'(t) * 32'h100, 32'h8000, 32'h9000, 32'hA000,
               11'(8 * (t + 1)), 4'(t));
    drain();
    chk("b2b_peak_level", 64'(max_level), 64'd4);

    // Illegal commands: wrong mode, zero size, misaligned address
    eng_mode = 1;
    push_cmd(3'd5, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 11'd4, 4'd9);
    push_cmd(3'd1, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 11'd0, 4'd10);
    push_cmd(3'd2, 32'h1004, 32'h2000, 32'h3000, 32'h4000, 11'd4, 4'd11);
    repeat (6) @(posedge clk);
    #1;
    chk("illegal_level", 64'(queue_level), 64'd0);
    chk("illegal_busy",  64'(busy),        64'd0);
    chk("illegal_flag",  64'(err_bad_cmd), 64'd1);
    pulse_err_clr();
    #1 chk("illegal_clr", 64'(err_bad_cmd), 64'd0);
    // Set and clear on the same edge: set wins
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 3'd6; cmd_size = 11'd4; cmd_left = '0;
    cmd_right = '0; cmd_addsrc = '0; cmd_save = '0; err_clr = 1'b1;
    @(posedge clk);
    exp_bad = 1'b1;
    #2 cmd_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("set_beats_clr", 64'(err_bad_cmd), 64'd1);
    pulse_err_clr();

    // Start timeout, then the next queued job still runs
    eng_mode = 3;
    push_cmd(3'd1, 32'h100, 32'h200, 32'h300, 32'h400, 11'd16, 4'd5);
    push_cmd(3'd2, 32'h500, 32'h600, 32'h700, 32'h800, 11'd32, 4'd6);
    k = 0;
    while (!calc_init && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    chk("tmo_launch_seen", 64'(calc_init), 64'd1);
    @(negedge clk);
    eng_mode = 2;
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!done_valid && k < 40);
    chk("tmo_delay",    64'(k),                 64'd9);
    chk("tmo_err",      64'(done_err),          64'd1);
    chk("tmo_tag",      64'(done_tag),          64'd5);
    chk("tmo_sticky",   64'(err_start_timeout), 64'd1);
    drain();
    pulse_err_clr();
    #1 chk("tmo_clr", 64'(err_start_timeout), 64'd0);

    // Randomized job mix, including illegal commands
    eng_mode = 1;
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      j.mode = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      j.size = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      j.l = $urandom() & 32'hFFFF_FFF8;
      j.r = $urandom() & 32'hFFFF_FFF8;
      j.a = $urandom() & 32'hFFFF_FFF8;
      j.s = $urandom() & 32'hFFFF_FFF8;
      if ($urandom_range(0, 9) == 0) j.s = j.s | 32'($urandom_range(1, 7));
      j.tag = 4'($urandom_range(0, 15));
      push_cmd(j.mode, j.l, j.r, j.a, j.s, j.size, j.tag);
    end
    drain();
    pulse_err_clr();

    // Reset while a job is in WAIT_DONE with two more queued
    eng_mode = 0;
    exp_err_q.push_back(1'b0);
    push_cmd(3'd1, 32'h10, 32'h20, 32'h30, 32'h40, 11'd8, 4'd1);
    push_cmd(3'd2, 32'h50, 32'h60, 32'h70, 32'h80, 11'd8, 4'd2);
    push_cmd(3'd1, 32'h90, 32'hA0, 32'hB0, 32'hC0, 11'd8, 4'd3);
    k = 0;
    while (!calc_init && k < 20) begin
      @(posedge clk);
      #1 k++;
    end
    @(negedge clk);
    engine_state = 4'd7;
    repeat (4) @(negedge clk);
    chk("pre_rst_level", 64'(queue_level), 64'd3);
    chk("pre_rst_busy",  64'(busy),        64'd1);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("midrst_calc_init", 64'(calc_init),   64'd0);
    chk("midrst_busy",      64'(busy),        64'd0);
    chk("midrst_level",     64'(queue_level), 64'd0);
    chk("midrst_done",      64'(done_valid),  64'd0);
    engine_state = 4'd0;
    model_q.delete();
    exp_err_q.delete();
    model_level = 0; pop_pending = 0; due_active = 0; exp_bad = 0; exp_to = 0; prev_ci = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_done", 64'(done_valid), 64'd0);
      chk("postrst_no_init", 64'(calc_init),  64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_cmd_sched.md
Name: systolic_cmd_sched

Overview:
- Command scheduler in front of the systolic memory controller. Software or a top-level FSM pushes matrix jobs into a small queue: a mode, four base addresses, a matrix size and a tag.
- The block launches the jobs one at a time. For each job it drives the controller's configuration and a one-cycle calc_init, then tracks the controller's current_state to detect start and completion.
- It reports completion per job with the job's tag, and raises sticky error flags for illegal commands and start timeouts.

Parameters:
- FIFO_DEPTH, 4: command queue entries (power of two, ≥2).
- TAG_W, 4: width of the job tag.
- START_TIMEOUT, 8: cycles allowed in WAIT_START before a start timeout is declared.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: queue can accept a command.
- cmd_mode, in, 3: 1 = A·S, 2 = S·A.
- cmd_left, cmd_right, cmd_addsrc, cmd_save, in, 32 each: base addresses.
- cmd_size, in, 11: matrix size.
- cmd_tag, in, TAG_W: job identifier.
- engine_state, in, 4: controller current_state; 0 means IDLE.
- calc_init, out, 1: start pulse to the controller.
- mem_mode, out, 3: configuration to the controller.
- base_left, base_right, base_addsrc, base_save, out, 32 each: configuration to the controller.
- matrix_size, out, 11: configuration to the controller.
- done_valid, out, 1: one-cycle completion pulse.
- done_tag, out, TAG_W: tag of the completed job.
- done_err, out, 1: completion was caused by a timeout.
- busy, out, 1: high when the FSM is not in IDLE.
- queue_level, out, clog2(FIFO_DEPTH)+1: number of queued entries.
- err_bad_cmd, out, 1: sticky illegal-command flag.
- err_start_timeout, out, 1: sticky start-timeout flag.
- err_clr, in, 1: clears both sticky flags.

Behaviour:
- Reset: all outputs are 0, the queue is emptied and the FSM is in IDLE. This holds even mid-job; the controller is reset by the same domain.
- Push:
  - cmd_ready = !full. A command is accepted when cmd_valid && cmd_ready at a rising edge.
  - A pop and a push in the same cycle while full is not allowed, because cmd_ready is low.
- Legality check at push:
  - Legal: cmd_mode ∈ {1,2}, cmd_size ≠ 0, and all four addresses 8-byte aligned (low 3 bits = 0).
  - An illegal command is consumed (handshake completes) but not enqueued, and err_bad_cmd is set.
- FSM, one transition per edge:
  - IDLE: if the queue is non-empty, go to LAUNCH. The head entry is latched onto mem_mode, base_* and matrix_size.
  - LAUNCH: calc_init = 1 for exactly this one cycle. Next state is WAIT_START, and the timeout counter is cleared.
  - WAIT_START:
    - engine_state ≠ 0 → WAIT_DONE.
    - Otherwise the counter increments. When the counter reaches START_TIMEOUT-1 → DONE with done_err = 1, and err_start_timeout is set.
  - WAIT_DONE: engine_state == 0 → DONE.
  - DONE: done_valid = 1, done_tag = head tag, and the head is popped. Next state is IDLE.
- Configuration outputs stay stable from LAUNCH through DONE and hold their last value in IDLE.
- Launch latency: a command accepted at edge n into an empty idle block gives calc_init high in the cycle after edge n+2.
- After done_valid, the next queued job gets calc_init 2 cycles later (DONE→IDLE→LAUNCH).
- Sticky flags:
  - err_clr clears both flags.
  - A set event in the same cycle as err_clr wins (the flag stays 1).
  - The flags have no effect on scheduling.
- queue_level updates on push/pop edges. A simultaneous push and pop (possible only when not full) leaves it unchanged.
- engine_state values other than 0 are treated identically as "running".

Test Plan:
- Single job: push mode=1, size=64, left=0x1000, tag=3; engine_state goes 0→1 one cycle after calc_init, then returns to 0 after 100 cycles. Expect:
  - calc_init is a single pulse;
  - outputs show mem_mode=1, base_left=0x1000, matrix_size=64 throughout;
  - done_valid with done_tag=3 one cycle after engine_state returns to 0;
  - busy low after that.
- Back-to-back: push 4 jobs with tags 0..3 while the first job runs; a fifth push waits for cmd_ready. Expect done tags in order 0,1,2,3, queue_level peaks at 4, and 2 cycles between each done_valid and the next calc_init.
- Illegal commands: push mode=5, then size=0, then left=0x1004. Expect none launched, err_bad_cmd=1, and queue_level=0. Then pulse err_clr, expect err_bad_cmd=0.
- Timeout: push a legal job and hold engine_state=0. Expect done_valid with done_err=1 exactly START_TIMEOUT cycles after WAIT_START entry, and err_start_timeout=1. The next queued job still launches.
- Reset mid-job: assert rst during WAIT_DONE with 2 jobs queued. Expect immediate calc_init=0, busy=0, queue_level=0, and no done_valid after reset release.
